// File: rtl/mem_burst_master_if.sv
// ============================================================================
// mem_burst_master_if : command, write/read stream and memory-pin bundle for
//                       mem_burst_master. verify_err exists with WRITE_VERIFY_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface mem_burst_master_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] cmd_len;
  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              busy;
  logic              done;
`ifdef WRITE_VERIFY_EN
  logic              verify_err;
`endif
  logic              mem_wr_en;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

`ifdef WRITE_VERIFY_EN
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, mem_data_out,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done, verify_err,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, mem_data_out,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done, verify_err,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );
`else
  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, mem_data_out,
    output cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );
  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_data, wr_valid, mem_data_out,
    input  cmd_ready, wr_ready, rd_data, rd_valid, busy, done,
           mem_wr_en, mem_rd_en, mem_addr, mem_data_in
  );
`endif
endinterface

`default_nettype wire

// File: rtl/mem_burst_master.sv
// ============================================================================
// mem_burst_master : burst sequencer for a single-port memory (write/read
//                    bursts of 1..16 words). Optional macro WRITE_VERIFY_EN adds
//                    an XOR-checksum read-back after every write burst.
// Revision: 1.0
// ============================================================================
`default_nettype none

module mem_burst_master #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  wire logic           clk,
  input  wire logic           rst,
  mem_burst_master_if.master  bus
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WRITE  = 3'd1,
    READ   = 3'd2,
    DRAIN  = 3'd3,
`ifdef WRITE_VERIFY_EN
    VERIFY = 3'd5,
    VDRAIN = 3'd6,
`endif
    DONE   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rd_valid_q, rd_valid_d;

  logic              w_cmd_ready;
  logic              w_wr_ready;
  logic              w_done;
  logic              w_mem_wr_en;
  logic              w_mem_rd_en;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_data_in;

`ifdef WRITE_VERIFY_EN
  logic [ADDR_W-1:0] start_q, start_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] acc_w_q, acc_w_d;
  logic [DATA_W-1:0] acc_r_q, acc_r_d;
  logic              vpend_q, vpend_d;
  logic              verr_q, verr_d;
  logic [DATA_W-1:0] w_acc_r_final;
  logic              w_mismatch;

  // The last verify word is still on mem_data_out during VDRAIN.
  assign w_acc_r_final = acc_r_q ^ (vpend_q ? bus.mem_data_out : '0);
  assign w_mismatch    = (acc_w_q != w_acc_r_final);
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    cnt_d         = cnt_q;
    w_cmd_ready   = 1'b0;
    w_wr_ready    = 1'b0;
    w_done        = 1'b0;
    w_mem_wr_en   = 1'b0;
    w_mem_rd_en   = 1'b0;
    w_mem_addr    = '0;
    w_mem_data_in = '0;
`ifdef WRITE_VERIFY_EN
    start_d = start_q;
    len_d   = len_q;
    acc_w_d = acc_w_q;
    acc_r_d = vpend_q ? (acc_r_q ^ bus.mem_data_out) : acc_r_q;
    verr_d  = verr_q;
`endif

    case (state_q)
      IDLE: begin
        w_cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          ptr_d   = bus.cmd_addr;
          cnt_d   = bus.cmd_len;
          state_d = bus.cmd_write ? WRITE : READ;
`ifdef WRITE_VERIFY_EN
          start_d = bus.cmd_addr;
          len_d   = bus.cmd_len;
          acc_w_d = '0;
          acc_r_d = '0;
          verr_d  = 1'b0;
`endif
        end
      end

      WRITE: begin
        w_wr_ready    = 1'b1;
        w_mem_wr_en   = bus.wr_valid;
        w_mem_addr    = ptr_q;
        w_mem_data_in = bus.wr_data;
        if (bus.wr_valid) begin
          ptr_d = ptr_q + 1'b1;
          cnt_d = cnt_q - 1'b1;
`ifdef WRITE_VERIFY_EN
          acc_w_d = acc_w_q ^ bus.wr_data;
          if (cnt_q == '0) begin
            ptr_d   = start_q;
            cnt_d   = len_q;
            state_d = VERIFY;
          end
`else
          if (cnt_q == '0) state_d = DONE;
`endif
        end
      end

      READ: begin
        w_mem_rd_en = 1'b1;
        w_mem_addr  = ptr_q;
        ptr_d       = ptr_q + 1'b1;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DRAIN;
      end

      DRAIN: begin
        w_done  = 1'b1;
        state_d = IDLE;
      end

      DONE: begin
        w_done  = 1'b1;
        state_d = IDLE;
      end

`ifdef WRITE_VERIFY_EN
      VERIFY: begin
        w_mem_rd_en = 1'b1;
        w_mem_addr  = ptr_q;
        ptr_d       = ptr_q + 1'b1;
        cnt_d       = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = VDRAIN;
      end

      VDRAIN: begin
        w_done  = 1'b1;
        if (w_mismatch) verr_d = 1'b1;
        state_d = IDLE;
      end
`endif

      default: state_d = IDLE;
    endcase
  end

  // Verify reads never surface on the read stream.
  assign rd_valid_d = (state_q == READ);
`ifdef WRITE_VERIFY_EN
  assign vpend_d    = (state_q == VERIFY);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      cnt_q      <= '0;
      rd_valid_q <= 1'b0;
`ifdef WRITE_VERIFY_EN
      start_q    <= '0;
      len_q      <= '0;
      acc_w_q    <= '0;
      acc_r_q    <= '0;
      vpend_q    <= 1'b0;
      verr_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      rd_valid_q <= rd_valid_d;
`ifdef WRITE_VERIFY_EN
      start_q    <= start_d;
      len_q      <= len_d;
      acc_w_q    <= acc_w_d;
      acc_r_q    <= acc_r_d;
      vpend_q    <= vpend_d;
      verr_q     <= verr_d;
`endif
    end
  end

  assign bus.cmd_ready   = w_cmd_ready;
  assign bus.wr_ready    = w_wr_ready;
  assign bus.busy        = (state_q != IDLE);
  assign bus.done        = w_done;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.rd_data     = bus.mem_data_out;
  assign bus.mem_wr_en   = w_mem_wr_en;
  assign bus.mem_rd_en   = w_mem_rd_en;
  assign bus.mem_addr    = w_mem_addr;
  assign bus.mem_data_in = w_mem_data_in;
`ifdef WRITE_VERIFY_EN
  // Visible in the done cycle itself, then held by the sticky flop.
  assign bus.verify_err  = verr_q | ((state_q == VDRAIN) && w_mismatch);
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_master.sv
// ============================================================================
// tb_mem_burst_master : table-driven and random bursts against a 16x16 memory
//                       emulator, checked with an array-based reference model.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_master;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  typedef struct {
    bit          wr;
    int          addr;
    int          len;
    logic [15:0] base;
    logic [15:0] step;
    int          stall_at;
    int          stall_n;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  mem_burst_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Memory emulator: registered read, one-cycle latency, optional bit-0 flip.
  logic [DATA_W-1:0] emu_mem [DEPTH];
  logic [DATA_W-1:0] emu_q;
  logic              mem_clear;
  logic              flip_arm;
  logic [ADDR_W-1:0] flip_addr;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < DEPTH; i++) emu_mem[i] <= '0;
      emu_q <= '0;
    end else begin
      if (bus.mem_wr_en) emu_mem[bus.mem_addr] <= bus.mem_data_in;
      if (bus.mem_rd_en)
        emu_q <= emu_mem[bus.mem_addr] ^
                 ((flip_arm && bus.mem_addr == flip_addr) ? 16'h0001 : 16'h0000);
    end
  end
  assign bus.mem_data_out = emu_q;

  logic [15:0] ref_mem [DEPTH];
  int total = 0;
  int bad   = 0;
  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] word_of(input vec_t v, input int i);
    return v.base + 16'(i) * v.step;
  endfunction

  function automatic logic [3:0] addr_of(input vec_t v, input int i);
    return 4'((v.addr + i) % DEPTH);
  endfunction

  task automatic do_burst(input vec_t v, input bit hold, input bit exp_verr);
    int n, widx, ridx, vidx, done_cnt, done_cyc, last_hs, stall_left, lat, len1, exp_lat;
    bit verr_at_done;
    len1 = v.len + 1;
    widx = 0; ridx = 0; vidx = 0; done_cnt = 0; done_cyc = -1; last_hs = -1;
    stall_left = v.stall_n; lat = -1; verr_at_done = 1'b0;
    exp_lat = v.exp_lat;
`ifdef WRITE_VERIFY_EN
    if (v.wr) exp_lat = exp_lat + len1;
`endif
    @(negedge clk);
    check("idle_cmd_ready", bus.cmd_ready, 1);
    bus.cmd_valid = 1'b1;
    bus.cmd_write = v.wr;
    bus.cmd_addr  = 4'(v.addr);
    bus.cmd_len   = 4'(v.len);
    bus.wr_valid  = 1'b0;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (!hold) bus.cmd_valid = 1'b0;
      if (bus.wr_ready) begin
        if (widx == v.stall_at && stall_left > 0) begin
          bus.wr_valid = 1'b0;
          stall_left--;
        end else begin
          bus.wr_valid = 1'b1;
          bus.wr_data  = word_of(v, widx);
        end
      end else begin
        bus.wr_valid = 1'b0;
      end
      #1;
      if (bus.cmd_ready) begin
        lat = n;
        break;
      end
      if (bus.mem_wr_en && bus.mem_rd_en) check("wr_rd_exclusive", 1, 0);
      if (bus.wr_ready) check("wr_en_follows_valid", bus.mem_wr_en, bus.wr_valid);
      if (bus.mem_wr_en) begin
        check("wr_addr", bus.mem_addr, addr_of(v, widx));
        check("wr_data", bus.mem_data_in, word_of(v, widx));
        widx++;
        last_hs = n;
      end
      if (bus.mem_rd_en) begin
        check("rd_addr", bus.mem_addr, addr_of(v, ridx));
        ridx++;
      end
      if (bus.rd_valid) begin
        check("rd_data", bus.rd_data, ref_mem[addr_of(v, vidx)]);
        vidx++;
      end
      if (bus.done) begin
        done_cnt++;
        done_cyc = n;
`ifdef WRITE_VERIFY_EN
        verr_at_done = bus.verify_err;
`endif
      end
    end
    check("ready_latency", lat, exp_lat);
    check("done_count", done_cnt, 1);
    if (v.wr) begin
      check("words_written", widx, len1);
      check("no_rd_valid_on_write", vidx, 0);
`ifdef WRITE_VERIFY_EN
      check("done_after_verify", done_cyc, last_hs + len1 + 1);
      check("verify_reads", ridx, len1);
      check("verify_err_at_done", verr_at_done, exp_verr);
      check("verify_err_sticky", bus.verify_err, exp_verr);
`else
      check("done_after_last_write", done_cyc, last_hs + 1);
      if (exp_verr) check("verify_err_unsupported", 0, 1);
`endif
      for (int i = 0; i < len1; i++) ref_mem[addr_of(v, i)] = word_of(v, i);
    end else begin
      check("reads_issued", ridx, len1);
      check("rd_valid_count", vidx, len1);
      check("done_cycle_read", done_cyc, len1 + 1);
    end
  endtask

  initial begin
    vec_t rv;
    int n, ridx, done_seen;
    rst = 1'b1; mem_clear = 1'b1; flip_arm = 1'b0; flip_addr = '0;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = '0; bus.cmd_len = '0;
    bus.wr_data = '0; bus.wr_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

    //          wr    addr len base     step     stall_at n lat
    vecs[0] = '{1'b1, 2,   3,  16'h1111, 16'h1111, 99, 0, 6};
    vecs[1] = '{1'b0, 2,   3,  16'h0000, 16'h0000, 99, 0, 6};
    vecs[2] = '{1'b1, 14,  3,  16'hA0A0, 16'h0101, 99, 0, 6};
    vecs[3] = '{1'b0, 14,  3,  16'h0000, 16'h0000, 99, 0, 6};
    vecs[4] = '{1'b1, 5,   6,  16'h5000, 16'h0011, 3,  3, 12};
    vecs[5] = '{1'b0, 5,   6,  16'h0000, 16'h0000, 99, 0, 9};
    vecs[6] = '{1'b0, 0,   0,  16'h0000, 16'h0000, 99, 0, 3};
    vecs[7] = '{1'b1, 9,   0,  16'hBEEF, 16'h0000, 99, 0, 3};

    repeat (3) @(negedge clk);
    mem_clear = 1'b0;
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_wr_ready", bus.wr_ready, 0);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_mem_wr_en", bus.mem_wr_en, 0);
    check("rst_mem_rd_en", bus.mem_rd_en, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_data_in", bus.mem_data_in, 0);
    check("rst_rd_data_follows", bus.rd_data, bus.mem_data_out);
`ifdef WRITE_VERIFY_EN
    check("rst_verify_err", bus.verify_err, 0);
`endif
    rst = 1'b0;

    for (int i = 0; i < 8; i++) do_burst(vecs[i], 1'b0, 1'b0);

    // cmd_valid held through a 16-word read: next acceptance at C+18.
    rv = '{1'b0, 3, 15, 16'h0, 16'h0, 99, 0, 18};
    do_burst(rv, 1'b1, 1'b0);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    #1;
    check("held_cmd_accepted", bus.busy, 1);
    n = 0;
    while (!bus.cmd_ready && n < 40) begin
      @(negedge clk); #1; n++;
    end
    check("held_cmd_drained", bus.cmd_ready, 1);

    // Reset while issuing word 5 of an 8-word read.
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 4'd0; bus.cmd_len = 4'd7;
    ridx = 0; n = 0;
    while (n < 20) begin
      @(negedge clk); n++;
      bus.cmd_valid = 1'b0;
      #1;
      if (bus.mem_rd_en) ridx++;
      if (ridx == 5) begin
        rst = 1'b1;
        break;
      end
    end
    check("reset_reached_word5", ridx, 5);
    @(negedge clk);
    #1;
    rst = 1'b0;
    check("midrst_busy", bus.busy, 0);
    check("midrst_rd_valid", bus.rd_valid, 0);
    check("midrst_cmd_ready", bus.cmd_ready, 1);
    check("midrst_done", bus.done, 0);
    check("midrst_mem_rd_en", bus.mem_rd_en, 0);
    check("midrst_mem_addr", bus.mem_addr, 0);
    done_seen = 0;
    repeat (5) begin
      @(negedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("midrst_no_done", done_seen, 0);
    do_burst(vecs[1], 1'b0, 1'b0);

    for (int k = 0; k < 24; k++) begin
      rv.wr       = 1'($urandom % 2);
      rv.addr     = int'($urandom % DEPTH);
      rv.len      = int'($urandom % DEPTH);
      rv.base     = 16'($urandom);
      rv.step     = 16'($urandom);
      rv.stall_at = int'($urandom_range(0, rv.len));
      rv.stall_n  = rv.wr ? int'($urandom % 4) : 0;
      rv.exp_lat  = rv.len + 1 + 2 + rv.stall_n;
      do_burst(rv, 1'b0, 1'b0);
    end

`ifdef WRITE_VERIFY_EN
    rv = '{1'b1, 6, 3, 16'h1234, 16'h0F0F, 99, 0, 6};
    flip_arm  = 1'b1;
    flip_addr = 4'd6;
    do_burst(rv, 1'b0, 1'b1);
    flip_arm  = 1'b0;
    do_burst(rv, 1'b0, 1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
